operand_stack: RTL and testbench
================================

Name: operand_stack

Overview:
- Parametrised hardware operand stack for the stack-based CPU datapath.
- Holds DEPTH entries of WIDTH bits and exposes the top and penultimate entries combinationally to the ALU.
- One stack operation per clock, selected by a 3-bit opcode from Control.
- Adds what the fixed two-slot stack lacks: configurable width/depth, occupancy count, full/empty status, compound ALU-result ops (pop-two-push-one), DUP/SWAP, and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8: bits per stack entry.
- DEPTH, 16: number of entries; must be ≥ 2.
- CW, $clog2(DEPTH+1): width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- start  input  1  asynchronous, active-high reset.
- op  input  3  stack operation, encoding below.
- push_data  input  WIDTH  value written by PUSH / REPL1 / REPL2.
- clear_err  input  1  clears sticky error flags.
- top_val  output  WIDTH  entry at count-1; 0 when count = 0.
- pen_val  output  WIDTH  entry at count-2; 0 when count < 2.
- count  output  CW  current number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf_err  output  1  sticky overflow flag.
- unf_err  output  1  sticky underflow flag.

Behaviour:
- Reset (start = 1, asynchronous):
  - count = 0, ovf_err = 0, unf_err = 0.
  - Hence top_val = 0, pen_val = 0, empty = 1, full = 0.
  - Storage array contents are not reset; outputs are masked by count.
  - Reset asserted mid-operation discards the in-flight op.
- All state updates on the rising clk edge. Outputs are combinational from registered state, so an op's effect is visible the cycle after it is presented (latency 1).
- op encoding, with the legality condition for each:
  - 0 NOP: always legal; no change.
  - 1 PUSH: mem[count] <= push_data; count+1. Needs count < DEPTH.
  - 2 POP: count-1. Needs count ≥ 1.
  - 3 POP2: count-2. Needs count ≥ 2.
  - 4 REPL1: mem[count-1] <= push_data; count unchanged. Needs count ≥ 1.
  - 5 REPL2: mem[count-2] <= push_data; count-1. This is the binary-ALU result op. Needs count ≥ 2.
  - 6 DUP: mem[count] <= mem[count-1]; count+1. Needs 1 ≤ count < DEPTH.
  - 7 SWAP: exchange mem[count-1] and mem[count-2]; count unchanged. Needs count ≥ 2.
- Illegal op (condition not met):
  - No storage or count change.
  - ovf_err set if the failure was the DEPTH limit (PUSH, or DUP when full).
  - unf_err set if the failure was too few entries.
  - DUP on an empty stack sets unf_err only.
- count never wraps: it cannot go below 0 or above DEPTH.
- Error flags:
  - Stay set until start, or until a clock edge with clear_err = 1.
  - If clear_err and a new error occur on the same edge, the new error wins and the flag is left set; the other flag clears.
- Arithmetic is pure storage; push_data is stored unmodified, with no sign handling.
- With DEPTH = 2 the block behaves as the legacy two-slot top/pen stack, plus flags.

Test Plan (WIDTH = 8, DEPTH = 4):
- Reset, then PUSH 0x11, 0x22, 0x33 → top_val = 0x33, pen_val = 0x22, count = 3, empty = 0, full = 0.
- From that state: PUSH 0x44, then PUSH 0x55 → after the first, full = 1 and count = 4; the second sets ovf_err = 1 with top_val still 0x44 and count still 4. NOP → ovf_err stays 1. clear_err → ovf_err = 0.
- Stack [0x11, 0x22] (top 0x22): SWAP → top = 0x11, pen = 0x22. REPL2 push_data = 0x33 → count = 1, top = 0x33, pen = 0. DUP → count = 2, top = pen = 0x33.
- Empty stack: POP → unf_err = 1, count = 0, top_val = 0. Then with count = 1: POP2 → unf_err = 1, count stays 1. Same-edge clear_err plus illegal POP2 → unf_err stays 1.
- Assert start asynchronously between edges with count = 3 and both error flags set → count, ovf_err and unf_err read 0 immediately, before the next edge; empty = 1. After release, PUSH 0x5A → top = 0x5A, pen = 0.
- Full stack [0x01, 0x02, 0x03, 0x04]: DUP → ovf_err = 1, no change. REPL1 push_data = 0xFF → top = 0xFF, count = 4. POP2 then POP2 → count = 0, empty = 1, no error.

Source files
------------

// File: rtl/operand_stack.sv
// Operand stack for the stack CPU datapath: one push/pop/replace/dup/swap op per clock,
// top and penultimate entries exposed combinationally, with sticky overflow/underflow flags.
module operand_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] top_val,
  output logic [WIDTH-1:0] pen_val,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_POP2  = 3'd3;
  localparam logic [2:0] OP_REPL1 = 3'd4;
  localparam logic [2:0] OP_REPL2 = 3'd5;
  localparam logic [2:0] OP_DUP   = 3'd6;
  localparam logic [2:0] OP_SWAP  = 3'd7;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_evt, unf_evt;
  logic             has1, has2, not_full;
  logic             wr0_en, wr1_en;
  logic [CW-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0] wr0_dat, wr1_dat;

  // Reads are muxed on count so the array is never indexed by a wider count value.
  always_comb begin
    top_val = '0;
    pen_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) top_val = mem_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (count_q == CW'(i + 2)) pen_val = mem_q[i];
    end
  end

  assign has1     = (count_q != '0);
  assign has2     = (count_q >= TWO);
  assign not_full = (count_q != FULL_CNT);

  always_comb begin
    count_d = count_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    wr0_en  = 1'b0;
    wr0_idx = '0;
    wr0_dat = '0;
    wr1_en  = 1'b0;
    wr1_idx = '0;
    wr1_dat = '0;
    case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (not_full) begin
          wr0_en  = 1'b1;
          wr0_idx = count_q;
          wr0_dat = push_data;
          count_d = count_q + ONE;
        end else ovf_evt = 1'b1;
      end
      OP_POP: begin
        if (has1) count_d = count_q - ONE;
        else unf_evt = 1'b1;
      end
      OP_POP2: begin
        if (has2) count_d = count_q - TWO;
        else unf_evt = 1'b1;
      end
      OP_REPL1: begin
        if (has1) begin
          wr0_en  = 1'b1;
          wr0_idx = count_q - ONE;
          wr0_dat = push_data;
        end else unf_evt = 1'b1;
      end
      OP_REPL2: begin
        if (has2) begin
          wr0_en  = 1'b1;
          wr0_idx = count_q - TWO;
          wr0_dat = push_data;
          count_d = count_q - ONE;
        end else unf_evt = 1'b1;
      end
      OP_DUP: begin
        if (!has1) unf_evt = 1'b1;
        else if (!not_full) ovf_evt = 1'b1;
        else begin
          wr0_en  = 1'b1;
          wr0_idx = count_q;
          wr0_dat = top_val;
          count_d = count_q + ONE;
        end
      end
      OP_SWAP: begin
        if (has2) begin
          wr0_en  = 1'b1;
          wr0_idx = count_q - ONE;
          wr0_dat = pen_val;
          wr1_en  = 1'b1;
          wr1_idx = count_q - TWO;
          wr1_dat = top_val;
        end else unf_evt = 1'b1;
      end
      default: ;
    endcase
  end

  // A new error on the same edge as clear_err keeps that flag set.
  assign ovf_d = (ovf_q & ~clear_err) | ovf_evt;
  assign unf_d = (unf_q & ~clear_err) | unf_evt;

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; outputs are masked by count instead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!start && wr0_en && wr0_idx == CW'(i)) mem_q[i] <= wr0_dat;
      else if (!start && wr1_en && wr1_idx == CW'(i)) mem_q[i] <= wr1_dat;
    end
  end

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack (WIDTH=8, DEPTH=4): directed vector table, async reset sequence,
// then random ops against a queue-based reference model.
module tb_operand_stack;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          start = 1'b1;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  push_data = '0;
  logic          clear_err = 1'b0;
  logic [W-1:0]  top_val, pen_val;
  logic [CW-1:0] count;
  logic          empty, full, ovf_err, unf_err;

  int total = 0;
  int bad   = 0;

  operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .start(start), .op(op), .push_data(push_data), .clear_err(clear_err),
    .top_val(top_val), .pen_val(pen_val), .count(count), .empty(empty), .full(full),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] dat;
    logic       clr;
    logic [7:0] top;
    logic [7:0] pen;
    int         cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] t, input logic [7:0] p,
                           input int c, input logic o, input logic u);
    check({tag, ".top"},   32'(top_val), 32'(t));
    check({tag, ".pen"},   32'(pen_val), 32'(p));
    check({tag, ".count"}, 32'(count),   32'(c));
    check({tag, ".empty"}, 32'(empty),   32'(c == 0));
    check({tag, ".full"},  32'(full),    32'(c == D));
    check({tag, ".ovf"},   32'(ovf_err), 32'(o));
    check({tag, ".unf"},   32'(unf_err), 32'(u));
  endtask

  task automatic step(input logic [2:0] o, input logic [7:0] d, input logic c);
    op = o; push_data = d; clear_err = c;
    @(posedge clk);
    #1;
    op = 3'd0; clear_err = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b1;
    #3;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic [2:0] o, input logic [7:0] d, input logic c,
                             input logic [7:0] t, input logic [7:0] p, input int n,
                             input logic ov, input logic un);
    vec_t r;
    r.op = o; r.dat = d; r.clr = c; r.top = t; r.pen = p; r.cnt = n; r.ovf = ov; r.unf = un;
    return r;
  endfunction

  // Reference model: a plain queue, bottom at index 0.
  logic [7:0] mq[$];
  logic m_ovf, m_unf;

  task automatic model_op(input logic [2:0] o, input logic [7:0] d, input logic c);
    logic oe, ue;
    logic [7:0] tmp;
    oe = 1'b0; ue = 1'b0;
    case (o)
      3'd1: if (mq.size() < D) mq.push_back(d); else oe = 1'b1;
      3'd2: if (mq.size() >= 1) void'(mq.pop_back()); else ue = 1'b1;
      3'd3: if (mq.size() >= 2) begin void'(mq.pop_back()); void'(mq.pop_back()); end
            else ue = 1'b1;
      3'd4: if (mq.size() >= 1) mq[mq.size()-1] = d; else ue = 1'b1;
      3'd5: if (mq.size() >= 2) begin void'(mq.pop_back()); mq[mq.size()-1] = d; end
            else ue = 1'b1;
      3'd6: if (mq.size() == 0) ue = 1'b1;
            else if (mq.size() == D) oe = 1'b1;
            else mq.push_back(mq[mq.size()-1]);
      3'd7: if (mq.size() >= 2) begin
              tmp = mq[mq.size()-1];
              mq[mq.size()-1] = mq[mq.size()-2];
              mq[mq.size()-2] = tmp;
            end else ue = 1'b1;
      default: ;
    endcase
    m_ovf = (m_ovf & ~c) | oe;
    m_unf = (m_unf & ~c) | ue;
  endtask

  initial begin
    // Directed table, applied in order from reset.
    vecs.push_back(v(3'd1, 8'h11, 0, 8'h11, 8'h00, 1, 0, 0));
    vecs.push_back(v(3'd1, 8'h22, 0, 8'h22, 8'h11, 2, 0, 0));
    vecs.push_back(v(3'd1, 8'h33, 0, 8'h33, 8'h22, 3, 0, 0));
    vecs.push_back(v(3'd1, 8'h44, 0, 8'h44, 8'h33, 4, 0, 0));
    vecs.push_back(v(3'd1, 8'h55, 0, 8'h44, 8'h33, 4, 1, 0));
    vecs.push_back(v(3'd0, 8'h00, 0, 8'h44, 8'h33, 4, 1, 0));
    vecs.push_back(v(3'd0, 8'h00, 1, 8'h44, 8'h33, 4, 0, 0));
    vecs.push_back(v(3'd3, 8'h00, 0, 8'h22, 8'h11, 2, 0, 0));
    vecs.push_back(v(3'd7, 8'h00, 0, 8'h11, 8'h22, 2, 0, 0));
    vecs.push_back(v(3'd5, 8'h33, 0, 8'h33, 8'h00, 1, 0, 0));
    vecs.push_back(v(3'd6, 8'h00, 0, 8'h33, 8'h33, 2, 0, 0));
    vecs.push_back(v(3'd3, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(v(3'd2, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1));
    vecs.push_back(v(3'd1, 8'h66, 1, 8'h66, 8'h00, 1, 0, 0));
    vecs.push_back(v(3'd3, 8'h00, 0, 8'h66, 8'h00, 1, 0, 1));
    vecs.push_back(v(3'd3, 8'h00, 1, 8'h66, 8'h00, 1, 0, 1));
    vecs.push_back(v(3'd7, 8'h00, 1, 8'h66, 8'h00, 1, 0, 1));
    vecs.push_back(v(3'd5, 8'h77, 1, 8'h66, 8'h00, 1, 0, 1));
    vecs.push_back(v(3'd0, 8'h00, 1, 8'h66, 8'h00, 1, 0, 0));
    vecs.push_back(v(3'd2, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(v(3'd6, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1));
    vecs.push_back(v(3'd4, 8'h99, 0, 8'h00, 8'h00, 0, 0, 1));
    vecs.push_back(v(3'd0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(v(3'd1, 8'h01, 0, 8'h01, 8'h00, 1, 0, 0));
    vecs.push_back(v(3'd1, 8'h02, 0, 8'h02, 8'h01, 2, 0, 0));
    vecs.push_back(v(3'd1, 8'h03, 0, 8'h03, 8'h02, 3, 0, 0));
    vecs.push_back(v(3'd1, 8'h04, 0, 8'h04, 8'h03, 4, 0, 0));
    vecs.push_back(v(3'd6, 8'h00, 0, 8'h04, 8'h03, 4, 1, 0));
    vecs.push_back(v(3'd4, 8'hFF, 1, 8'hFF, 8'h03, 4, 0, 0));
    vecs.push_back(v(3'd3, 8'h00, 0, 8'h02, 8'h01, 2, 0, 0));
    vecs.push_back(v(3'd3, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));

    do_reset();
    check_all("reset", 8'h00, 8'h00, 0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].dat, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].top, vecs[i].pen, vecs[i].cnt,
                vecs[i].ovf, vecs[i].unf);
    end

    // Asynchronous reset between edges with count=3 and both flags set.
    do_reset();
    step(3'd2, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(3'd1, 8'(8'hA0 + i), 0);
    step(3'd2, 8'h00, 0);
    check_all("pre_arst", 8'hA2, 8'hA1, 3, 1'b1, 1'b1);
    #2;
    start = 1'b1;
    #1;
    check_all("arst_now", 8'h00, 8'h00, 0, 1'b0, 1'b0);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_all("arst_hold", 8'h00, 8'h00, 0, 1'b0, 1'b0);
    step(3'd1, 8'h5A, 0);
    check_all("arst_push", 8'h5A, 8'h00, 1, 1'b0, 1'b0);

    // Random ops against the queue model.
    do_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] ro;
      logic [7:0] rd;
      logic       rc;
      logic [7:0] et, ep;
      ro = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      rc = ($urandom_range(0, 7) == 0);
      model_op(ro, rd, rc);
      step(ro, rd, rc);
      et = (mq.size() >= 1) ? mq[mq.size()-1] : 8'h00;
      ep = (mq.size() >= 2) ? mq[mq.size()-2] : 8'h00;
      check_all($sformatf("rnd%0d", n), et, ep, mq.size(), m_ovf, m_unf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
